// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: round-robin arbiter driving a 4:1 data mux, with a bounded hold tenure
//   clk_in    : rising-edge clock
//   rst_n_in  : asynchronous active-low reset
//   req_in    : per-requester level request, held until served
//   d_in      : requester i word at d_in[i*DATA_W +: DATA_W]
//   gnt_out   : registered one-hot grant, zero when idle
//   sel_out   : registered index of the granted requester, holds when idle
//   y_out     : selected word, zero when no grant
//   valid_out : high while any grant is active
module rr_mux_arbiter_4 #(
   parameter int DATA_W   = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic [3:0]          req_in,
   input  logic [4*DATA_W-1:0] d_in,
   output logic [3:0]          gnt_out,
   output logic [1:0]          sel_out,
   output logic [DATA_W-1:0]   y_out,
   output logic                valid_out
);
   localparam int HW = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    last_q, last_d, sel_q, sel_d, win;
   logic [3:0]    gnt_q, gnt_d, others, cand;
   logic          own, rdy_q;
   // First requester with its bit set, searching upward from last+1 and wrapping.
   function automatic logic [1:0] rr_pick(input logic [3:0] m, input logic [1:0] last);
      logic [1:0] idx;
      rr_pick = last;
      for (int k = 3; k >= 0; k--) begin
         idx = last + 2'(k) + 2'd1;
         if (m[idx]) rr_pick = idx;
      end
   endfunction
   // While busy the owner is masked out: either it dropped its request or it is being rotated away.
   always_comb begin
      own     = |(req_in & gnt_q);
      others  = req_in & ~gnt_q;
      cand    = (state_q == BUSY) ? others : req_in;
      win     = rr_pick(cand, last_q);
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      if (state_q == BUSY && own && (hold_q != HMAX || others == 4'b0)) begin
         hold_d = (hold_q == HMAX) ? hold_q : hold_q + HW'(1);
      end else if (|cand) begin
         state_d = BUSY;
         gnt_d   = 4'b0001 << win;
         sel_d   = win;
         last_d  = win;
         hold_d  = HW'(1);
      end else if (state_q == BUSY) begin
         state_d = IDLE;
         gnt_d   = 4'b0;
         hold_d  = '0;
      end
   end
   // rdy_q holds the arbiter still for the first edge after reset release.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         hold_q  <= '0;
         last_q  <= 2'd3;
         sel_q   <= 2'd0;
         gnt_q   <= 4'b0;
         rdy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (rdy_q) begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
         end
      end
   end
   assign gnt_out   = gnt_q;
   assign sel_out   = sel_q;
   assign valid_out = |gnt_q;
   assign y_out     = valid_out ? d_in[sel_q*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb_rr_mux_arbiter_4: vector table, reset corner cases and random traffic against a reference model
module tb_rr_mux_arbiter_4;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_a, req_b;
   logic [31:0] d;
   logic [3:0]  gnt_a, gnt_b;
   logic [1:0]  sel_a, sel_b;
   logic [7:0]  y_a, y_b;
   logic        val_a, val_b;
   int          checks = 0;
   int          failures = 0;
   // reference model state: owner (-1 idle), tenure count, last winner, select, ready
   int          m_own[2], m_cnt[2], m_last[2], m_sel[2], m_rdy[2];
   int          hm[2] = '{4, 1};
   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt_a;
      logic [1:0] sel_a;
      logic [3:0] gnt_b;
   } vec_t;
   vec_t vt[25];

   always #5 clk = ~clk;

   rr_mux_arbiter_4 #(.DATA_W(8), .HOLD_MAX(4)) dut_a (
      .clk_in(clk), .rst_n_in(rst_n), .req_in(req_a), .d_in(d),
      .gnt_out(gnt_a), .sel_out(sel_a), .y_out(y_a), .valid_out(val_a));
   rr_mux_arbiter_4 #(.DATA_W(8), .HOLD_MAX(1)) dut_b (
      .clk_in(clk), .rst_n_in(rst_n), .req_in(req_b), .d_in(d),
      .gnt_out(gnt_b), .sel_out(sel_b), .y_out(y_b), .valid_out(val_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] word(input int i);
      logic [31:0] t = d;
      return t[i*8 +: 8];
   endfunction

   function automatic int pick(input logic [3:0] r, input int last, input int excl);
      for (int j = 1; j <= 4; j++) begin
         int c = (last + j) % 4;
         if (r[c] && c != excl) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_own[k] = -1; m_cnt[k] = 0; m_last[k] = 3; m_sel[k] = 0; m_rdy[k] = 0;
      end
   endtask

   task automatic grant(input int k, input int w);
      m_own[k] = w; m_last[k] = w; m_sel[k] = w; m_cnt[k] = 1;
   endtask

   task automatic model_step(input int k, input logic [3:0] r);
      int  o;
      bit  oth;
      if (m_rdy[k] == 0) begin
         m_rdy[k] = 1;
         return;
      end
      if (m_own[k] < 0) begin
         if (r != 4'b0) grant(k, pick(r, m_last[k], -1));
      end else begin
         o = m_own[k];
         oth = (r & ~(4'b1 << o)) != 4'b0;
         if (r[o] && (m_cnt[k] < hm[k] || !oth)) m_cnt[k] = (m_cnt[k] < hm[k]) ? m_cnt[k] + 1 : hm[k];
         else if (oth) grant(k, pick(r, m_last[k], o));
         else begin
            m_own[k] = -1; m_cnt[k] = 0;
         end
      end
   endtask

   task automatic compare_model();
      logic [3:0] eg;
      for (int k = 0; k < 2; k++) begin
         eg = (m_own[k] < 0) ? 4'b0 : 4'b1 << m_own[k];
         check(k == 0 ? "model_gnt_a" : "model_gnt_b", k == 0 ? gnt_a : gnt_b, eg);
         check(k == 0 ? "model_sel_a" : "model_sel_b", k == 0 ? sel_a : sel_b, m_sel[k]);
         check(k == 0 ? "model_val_a" : "model_val_b", k == 0 ? val_a : val_b, m_own[k] >= 0);
         check(k == 0 ? "model_y_a" : "model_y_b", k == 0 ? y_a : y_b,
               (m_own[k] < 0) ? 8'h00 : word(m_own[k]));
      end
   endtask

   // inputs are driven before this is called; the model advances with the same inputs the edge sees
   task automatic cycle();
      model_step(0, req_a);
      model_step(1, req_b);
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic rand_req(inout logic [3:0] r, input int own);
      for (int i = 0; i < 4; i++) begin
         if (r[i] && own == i) r[i] = ($urandom_range(0, 2) != 0);
         else if (!r[i]) r[i] = ($urandom_range(0, 3) == 0);
      end
   endtask

   initial begin
      vt[0]  = '{4'b0000, 4'b0000, 2'd0, 4'b0000};
      vt[1]  = '{4'b0100, 4'b0100, 2'd2, 4'b0100};
      vt[2]  = '{4'b0100, 4'b0100, 2'd2, 4'b0100};
      vt[3]  = '{4'b0001, 4'b0001, 2'd0, 4'b0001};
      vt[4]  = '{4'b1000, 4'b1000, 2'd3, 4'b1000};
      vt[5]  = '{4'b0000, 4'b0000, 2'd3, 4'b0000};
      vt[6]  = '{4'b1111, 4'b0001, 2'd0, 4'b0001};
      vt[7]  = '{4'b1111, 4'b0001, 2'd0, 4'b0010};
      vt[8]  = '{4'b1111, 4'b0001, 2'd0, 4'b0100};
      vt[9]  = '{4'b1111, 4'b0001, 2'd0, 4'b1000};
      vt[10] = '{4'b1111, 4'b0010, 2'd1, 4'b0001};
      vt[11] = '{4'b1111, 4'b0010, 2'd1, 4'b0010};
      vt[12] = '{4'b1111, 4'b0010, 2'd1, 4'b0100};
      vt[13] = '{4'b1111, 4'b0010, 2'd1, 4'b1000};
      vt[14] = '{4'b1111, 4'b0100, 2'd2, 4'b0001};
      for (int i = 15; i < 25; i++) vt[i] = '{4'b0010, 4'b0010, 2'd1, 4'b0010};

      rst_n = 1'b0;
      req_a = 4'b0;
      req_b = 4'b0;
      d     = 32'hD3C2B1A0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_gnt", gnt_a, 4'b0);
      check("reset_sel", sel_a, 2'd0);
      check("reset_val", val_a, 1'b0);
      check("reset_y", y_a, 8'h00);
      check("reset_gnt_b", gnt_b, 4'b0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         req_a = vt[i].req;
         req_b = vt[i].req;
         cycle();
         check("vec_gnt_a", gnt_a, vt[i].gnt_a);
         check("vec_sel_a", sel_a, vt[i].sel_a);
         check("vec_val_a", val_a, vt[i].gnt_a != 4'b0);
         check("vec_y_a", y_a, (vt[i].gnt_a != 4'b0) ? word(vt[i].sel_a) : 8'h00);
         check("vec_gnt_b", gnt_b, vt[i].gnt_b);
      end

      // asynchronous reset between edges while requester 1 owns the bus
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_gnt", gnt_a, 4'b0);
      check("async_val", val_a, 1'b0);
      check("async_y", y_a, 8'h00);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      req_a = 4'b1001;
      req_b = 4'b1001;
      cycle();
      check("release_hold_gnt", gnt_a, 4'b0);
      cycle();
      check("release_gnt", gnt_a, 4'b0001);
      check("release_sel", sel_a, 2'd0);
      // owner drops with nobody waiting: idle, select keeps its value
      @(negedge clk);
      req_a = 4'b1000;
      req_b = 4'b1000;
      cycle();
      check("drop_regrant", gnt_a, 4'b1000);
      @(negedge clk);
      req_a = 4'b0000;
      req_b = 4'b0000;
      cycle();
      check("idle_gnt", gnt_a, 4'b0);
      check("idle_sel_kept", sel_a, 2'd3);
      check("idle_y", y_a, 8'h00);

      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         d = $urandom;
         rand_req(req_a, m_own[0]);
         rand_req(req_b, m_own[1]);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
